// File: rtl/shift_add_multiplier_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_multiplier_pkg
//  Brief    : Shared CPU datapath definitions for the sequential multiplier:
//             FSM state encoding and datapath width constants.
//  Revision : 1.0 - initial release
// ============================================================================
package shift_add_multiplier_pkg;

  // Operand width (matches the carry-lookahead adder) and iteration counter width
  localparam int unsigned C_WIDTH = 8;
  localparam int unsigned C_CNT_W = 3;

  // Multiplier sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage : shift_add_multiplier_pkg
`default_nettype wire

// File: rtl/shift_add_multiplier_adder.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_multiplier_adder
//  Brief    : WIDTH-bit carry-lookahead adder. Every carry is formed directly
//             from the generate/propagate terms and the carry-in, so no carry
//             ripples through earlier sum bits.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_add_multiplier_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH-1:0] w_gen;
  logic [WIDTH-1:0] w_prop;
  logic [WIDTH:0]   w_carry;
  logic             w_term;

  assign w_gen  = i_a & i_b;
  assign w_prop = i_a ^ i_b;

  // Lookahead carries: c[i+1] = OR_j (g[j] & p[j+1..i]) | (cin & p[0..i])
  always_comb begin
    w_carry    = '0;
    w_term     = 1'b0;
    w_carry[0] = i_cin;
    for (int i = 0; i < WIDTH; i++) begin
      w_term = i_cin;
      for (int k = 0; k <= i; k++) begin
        w_term = w_term & w_prop[k];
      end
      w_carry[i+1] = w_term;
      for (int j = 0; j <= i; j++) begin
        w_term = w_gen[j];
        for (int k = j + 1; k <= i; k++) begin
          w_term = w_term & w_prop[k];
        end
        w_carry[i+1] = w_carry[i+1] | w_term;
      end
    end
  end

  assign o_sum  = w_prop ^ w_carry[WIDTH-1:0];
  assign o_cout = w_carry[WIDTH];

endmodule : shift_add_multiplier_adder
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_multiplier
//  Brief    : Sequential 8x8 unsigned shift-add multiplier. One partial-product
//             accumulation per clock through a single carry-lookahead adder;
//             Start/Busy/Done handshake, 16-bit product {Hi, Lo}.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = C_WIDTH,
  parameter int CNT_W = C_CNT_W
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] P
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;

  // Add the multiplicand only when the current multiplier LSB is set
  assign w_addend = lo_q[0] ? m_q : '0;

  shift_add_multiplier_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a    (hi_q),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Next-state, operand load and shift/accumulate step
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE behaves like IDLE for accepting Start, giving back-to-back ops
        if (Start) begin
          m_d     = A;
          hi_d    = '0;
          lo_d    = B;
          count_d = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // 9-bit {cout, sum} shifted right by one across Hi:Lo; cout must survive
        hi_d    = {w_cout, w_sum[WIDTH-1:1]};
        lo_d    = {w_sum[0], lo_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears any partial result at once
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      count_q <= count_d;
    end
  end

  assign Busy = (state_q == ST_RUN);
  assign Done = (state_q == ST_DONE);
  assign P    = {hi_q, lo_q};

endmodule : shift_add_multiplier
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_add_multiplier
//  Brief    : Self-checking bench for shift_add_multiplier: table of directed
//             products plus hand-written handshake corner sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        Busy;
  logic        Done;
  logic [15:0] P;

  int total;
  int bad;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs [8];

  shift_add_multiplier dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (Start),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done),
    .P       (P)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present operands in the low phase so they are accepted on the next edge
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge Clk);
    Start = 1'b1;
    A     = a;
    B     = b;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    A     = 8'($urandom);
    B     = 8'($urandom);
  endtask

  // 8 busy cycles, one Done cycle with the product, then product held in IDLE
  task automatic expect_run(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      check({tag, "_busy"}, {30'd0, Busy, Done}, 32'b10);
    end
    @(negedge Clk);
    check({tag, "_done"}, {30'd0, Busy, Done}, 32'b01);
    check({tag, "_p"}, {16'd0, P}, {16'd0, exp});
    @(negedge Clk);
    check({tag, "_idle"}, {30'd0, Busy, Done}, 32'b00);
    check({tag, "_hold"}, {16'd0, P}, {16'd0, exp});
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    Reset_n = 1'b0;
    Start   = 1'b0;
    A       = 8'd0;
    B       = 8'd0;

    vecs[0] = '{a: 8'd13,  b: 8'd11,  p: 16'd143};
    vecs[1] = '{a: 8'd255, b: 8'd255, p: 16'hFE01};
    vecs[2] = '{a: 8'h80,  b: 8'h02,  p: 16'h0100};
    vecs[3] = '{a: 8'd0,   b: 8'd200, p: 16'd0};
    vecs[4] = '{a: 8'd200, b: 8'd0,   p: 16'd0};
    vecs[5] = '{a: 8'd1,   b: 8'd255, p: 16'd255};
    vecs[6] = '{a: 8'd255, b: 8'd1,   p: 16'd255};
    vecs[7] = '{a: 8'd16,  b: 8'd16,  p: 16'd256};

    // Reset state
    #12;
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_done", {31'd0, Done}, 32'd0);
    check("reset_p", {16'd0, P}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check("idle_no_start", {30'd0, Busy, Done}, 32'b00);

    // Directed product table
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b);
      expect_run($sformatf("vec%0d", i), vecs[i].p);
    end

    // Product stays held in IDLE for a while after completion
    repeat (5) @(negedge Clk);
    check("long_hold_p", {16'd0, P}, {16'd0, vecs[7].p});

    // Start while busy is ignored: 3*5 completes, 7*7 never sampled
    start_op(8'd3, 8'd5);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      check("ign_busy", {30'd0, Busy, Done}, 32'b10);
      if (i == 3) begin
        Start = 1'b1;
        A     = 8'd7;
        B     = 8'd7;
      end else if (i == 4) begin
        Start = 1'b0;
      end
    end
    @(negedge Clk);
    check("ign_done", {30'd0, Busy, Done}, 32'b01);
    check("ign_p", {16'd0, P}, 32'd15);
    @(negedge Clk);
    check("ign_single_pulse", {30'd0, Busy, Done}, 32'b00);
    check("ign_hold", {16'd0, P}, 32'd15);

    // Back-to-back: Start held through Done launches the next op immediately
    start_op(8'd6, 8'd7);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      check("b2b_busy1", {30'd0, Busy, Done}, 32'b10);
    end
    Start = 1'b1;
    A     = 8'd2;
    B     = 8'd9;
    @(negedge Clk);
    check("b2b_done1", {30'd0, Busy, Done}, 32'b01);
    check("b2b_p1", {16'd0, P}, 32'd42);
    @(posedge Clk);
    #1;
    Start = 1'b0;
    A     = 8'd0;
    B     = 8'd0;
    expect_run("b2b2", 16'd18);

    // Asynchronous reset between edges in the 5th busy cycle
    start_op(8'd9, 8'd9);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("rst_pre_busy", {30'd0, Busy, Done}, 32'b10);
    end
    #2;
    Reset_n = 1'b0;
    #1;
    check("rst_async_ctl", {30'd0, Busy, Done}, 32'b00);
    check("rst_async_p", {16'd0, P}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      check("rst_after_idle", {30'd0, Busy, Done}, 32'b00);
      check("rst_after_p", {16'd0, P}, 32'd0);
    end
    start_op(8'd10, 8'd10);
    expect_run("post_rst", 16'd100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_shift_add_multiplier
`default_nettype wire

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential 8x8 unsigned multiplier for the CPU datapath; returns a 16-bit product.
- Uses the shift-add method: one partial-product accumulation per clock, through a single instance of the team's 8-bit carry-lookahead Adder.
- Sits upstream of the Adder, which it drives every cycle. Downstream, it feeds the ALU result mux and the register file write port.
- Start/Busy/Done handshake with the control unit.

Parameters:
- WIDTH, 8, operand width. Fixed to the Adder width; only 8 is supported.
- CNT_W, 3, iteration counter width, equal to log2(WIDTH).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  request a multiply. Sampled only when Busy=0.
- A  input  8  multiplicand; sampled on an accepted Start.
- B  input  8  multiplier; sampled on an accepted Start.
- Busy  output  1  high while iterating.
- Done  output  1  one-cycle pulse when P holds the final product.
- P  output  16  product register {Hi, Lo}.

Behaviour:
- Reset (asynchronous, Reset_n=0): state=IDLE, M=0, Hi=0, Lo=0, count=0, Busy=0, Done=0, P=0. Takes effect immediately, including mid-RUN. No partial result survives reset.
- States: IDLE, RUN, DONE.
- IDLE, Start=1 at an edge:
  - M<=A, Hi<=0, Lo<=B, count<=0.
  - Go to RUN.
- IDLE, Start=0: stay in IDLE.
- RUN, each edge:
  - Adder inputs: A=Hi, B=(Lo[0] ? M : 8'h00), Cin=0. Outputs: sum S, carry Cout.
  - Hi<={Cout, S[7:1]}, Lo<={S[0], Lo[7:1]} (9-bit result shifted right by one).
  - count<=count+1.
  - When count==7 at the edge, go to DONE instead of staying in RUN.
- DONE:
  - Done=1 for exactly one cycle; P is final.
  - Next edge: if Start=1, accept new operands exactly as from IDLE and go to RUN (back-to-back); otherwise go to IDLE.
- Outputs: Busy=(state==RUN), Done=(state==DONE); both decoded combinationally from the state register. P={Hi, Lo}.
- Latency:
  - Start accepted at edge k.
  - Busy=1 for the 8 cycles following edges k..k+7.
  - Done=1 in the cycle following edge k+8.
  - Result valid from edge k+8 until the next accepted Start.
- P during RUN shows partial products and is not valid. After DONE→IDLE, P holds its value indefinitely.
- Start while Busy=1 is ignored. No restart, no queuing, operands not re-sampled.
- A and B may change freely after the accepting edge.
- Width rules:
  - Product never exceeds 16 bits (255*255=65025).
  - The Cout shifted into Hi[7] is required for correctness; it must not be dropped.
- Counter wraps 7→0 only on the DONE transition. It is never observed outside RUN.

Decomposition:
- Shared package / include (cpu_defs):
  - state encoding IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - WIDTH=8 and CNT_W=3 constants.
- Exactly one sub-module: one Adder instance (8-bit CLA) for the accumulate step. No second adder; the counter increment is a plain 3-bit register.
- Remaining logic (FSM, shift register, operand mux) stays in this module.

Test Plan:
- Basic multiply: reset, then Start with A=13, B=11 → Busy high for 8 cycles, Done pulses once on the 9th cycle after the accepting edge, P=16'd143 (0x008F); P holds 143 in IDLE afterwards.
- Carry-out path: A=255, B=255 → P=16'hFE01. Also A=8'h80, B=8'h02 → P=16'h0100.
- Zero operands: A=0, B=200 → P=0; A=200, B=0 → P=0; Done timing identical to non-zero cases.
- Start ignored while busy: Start A=3, B=5; reassert Start with A=7, B=7 on the 4th Busy cycle → completes with P=15 and a single Done pulse.
- Back-to-back: Start held high through the Done cycle with A=2, B=9 after a 6*7 run → first Done shows P=42, Busy rises next cycle, second Done shows P=18.
- Reset mid-operation: assert Reset_n=0 asynchronously (between clock edges) on the 5th Busy cycle → Busy, Done, P go to 0 immediately; after release, state IDLE; a new Start with A=10, B=10 yields P=100.
